// File: rtl/pipelined_lane_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_lane_adder_if
// Description : Operand/result stream bundle for pipelined_lane_adder.
//               in_sub exists only when PLADD_SUB_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
interface pipelined_lane_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
`ifdef PLADD_SUB_EN
    logic             in_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport master (
`ifdef PLADD_SUB_EN
        output in_sub,
`endif
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
    );

    modport slave (
`ifdef PLADD_SUB_EN
        input  in_sub,
`endif
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_lane_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_lane_adder
// Description : WIDTH-bit a+b+cin adder, LANE bits per pipeline stage, with
//               valid/ready flow control and bubble collapse.
//               Optional subtract path enabled by macro PLADD_SUB_EN.
// Revision    : 1.0  initial release
// ============================================================================
module pipelined_lane_adder #(
    parameter int WIDTH = 8,
    parameter int LANE  = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pipelined_lane_adder_if.slave io
);
    localparam int c_stages = WIDTH / LANE;

    logic [c_stages-1:0] r_v;
    logic [c_stages-1:0] r_c;
    logic [WIDTH-1:0]    r_sum [c_stages];
    logic [WIDTH-1:0]    r_a   [c_stages];
    logic [WIDTH-1:0]    r_b   [c_stages];

    logic [c_stages-1:0] w_rdy;
    logic [c_stages-1:0] w_src_v;
    logic [c_stages-1:0] w_src_c;
    logic [c_stages-1:0] w_nxt_c;
    logic [WIDTH-1:0]    w_src_a   [c_stages];
    logic [WIDTH-1:0]    w_src_b   [c_stages];
    logic [WIDTH-1:0]    w_src_sum [c_stages];
    logic [WIDTH-1:0]    w_nxt_sum [c_stages];

    // Same sum/majority-carry slice as the original 2-bit ripple adder, LANE wide
    function automatic logic [LANE:0] f_add_lane(
        input logic [LANE-1:0] a,
        input logic [LANE-1:0] b,
        input logic            c
    );
        logic [LANE-1:0] s;
        logic            cy;
        s  = '0;
        cy = c;
        for (int i = 0; i < LANE; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (a[i] & cy) | (b[i] & cy);
        end
        return {cy, s};
    endfunction

    // A stage can load when empty or when the stage after it can move
    always_comb begin
        w_rdy = '0;
        w_rdy[c_stages-1] = ~r_v[c_stages-1] | io.out_ready;
        for (int k = c_stages - 2; k >= 0; k--) begin
            w_rdy[k] = ~r_v[k] | w_rdy[k+1];
        end
    end

    assign w_src_v[0]   = io.in_valid;
    assign w_src_a[0]   = io.in_a;
    assign w_src_sum[0] = '0;
`ifdef PLADD_SUB_EN
    // Two's-complement subtract folded into stage 0: invert b, add one via carry
    assign w_src_b[0]   = io.in_b ^ {WIDTH{io.in_sub}};
    assign w_src_c[0]   = io.in_cin ^ io.in_sub;
`else
    assign w_src_b[0]   = io.in_b;
    assign w_src_c[0]   = io.in_cin;
`endif

    for (genvar k = 1; k < c_stages; k++) begin : g_src
        assign w_src_v[k]   = r_v[k-1];
        assign w_src_c[k]   = r_c[k-1];
        assign w_src_a[k]   = r_a[k-1];
        assign w_src_b[k]   = r_b[k-1];
        assign w_src_sum[k] = r_sum[k-1];
    end

    for (genvar k = 0; k < c_stages; k++) begin : g_lane
        localparam logic [WIDTH-1:0] c_mask = WIDTH'({LANE{1'b1}}) << (k * LANE);
        logic [LANE:0] w_res;

        assign w_res        = f_add_lane(w_src_a[k][k*LANE +: LANE],
                                         w_src_b[k][k*LANE +: LANE],
                                         w_src_c[k]);
        assign w_nxt_c[k]   = w_res[LANE];
        assign w_nxt_sum[k] = (w_src_sum[k] & ~c_mask)
                            | (WIDTH'(w_res[LANE-1:0]) << (k * LANE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
            r_c <= '0;
            for (int k = 0; k < c_stages; k++) begin
                r_sum[k] <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < c_stages; k++) begin
                if (w_rdy[k]) begin
                    r_v[k]   <= w_src_v[k];
                    r_c[k]   <= w_nxt_c[k];
                    r_sum[k] <= w_nxt_sum[k];
                    r_a[k]   <= w_src_a[k];
                    r_b[k]   <= w_src_b[k];
                end
            end
        end
    end

    assign io.in_ready  = w_rdy[0];
    assign io.out_valid = r_v[c_stages-1];
    assign io.out_sum   = r_sum[c_stages-1];
    assign io.out_cout  = r_c[c_stages-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_lane_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_lane_adder
// Description : Directed-vector bench for pipelined_lane_adder (WIDTH=8, LANE=2).
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_lane_adder;
    localparam int WIDTH  = 8;
    localparam int LANE   = 2;
    localparam int STAGES = WIDTH / LANE;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    vec_t tbl [16];

    pipelined_lane_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_lane_adder #(.WIDTH(WIDTH), .LANE(LANE)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input int idx, input logic vld);
        bus.in_valid = vld;
        bus.in_a     = tbl[idx].a;
        bus.in_b     = tbl[idx].b;
        bus.in_cin   = tbl[idx].cin;
    endtask

    // Single beat into an empty pipe: latency, result, one-cycle valid
    task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic [7:0] es, input logic ec, input string nm);
        int lat;
        lat = 0;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = cin;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = i;
                check({nm, "_sum"},  32'(bus.out_sum),  32'(es));
                check({nm, "_cout"}, 32'(bus.out_cout), 32'(ec));
            end
        end
        check({nm, "_latency"}, 32'(lat), 32'(STAGES));
        @(negedge clk);
        check({nm, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic drain(input int first, input int n, input string nm);
        int rx;
        rx = 0;
        for (int i = 0; i < 12 && rx < n; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                check($sformatf("%s_sum%0d", nm, rx),  32'(bus.out_sum),  32'(tbl[first+rx].sum));
                check($sformatf("%s_cout%0d", nm, rx), 32'(bus.out_cout), 32'(tbl[first+rx].cout));
                rx++;
            end
        end
        check({nm, "_count"}, 32'(rx), 32'(n));
    endtask

    initial begin
        int rx;
        int gap;
        int stray;
        logic [7:0] held;

        n_tests = 0;
        n_fail  = 0;
        tbl[0]  = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0};
        tbl[1]  = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        tbl[2]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[4]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[5]  = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        tbl[6]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        tbl[7]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        tbl[8]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        tbl[9]  = '{8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1};
        tbl[10] = '{8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1};
        tbl[11] = '{8'h64, 8'h64, 1'b1, 8'hC9, 1'b0};
        tbl[12] = '{8'h01, 8'h02, 1'b1, 8'h04, 1'b0};
        tbl[13] = '{8'hFE, 8'h01, 1'b0, 8'hFF, 1'b0};
        tbl[14] = '{8'h99, 8'h99, 1'b0, 8'h32, 1'b1};
        tbl[15] = '{8'h3A, 8'hC5, 1'b0, 8'hFF, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;
`ifdef PLADD_SUB_EN
        bus.in_sub    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_sum",   32'(bus.out_sum),   32'd0);
        check("reset_out_cout",  32'(bus.out_cout),  32'd0);
        check("reset_in_ready",  32'(bus.in_ready),  32'd1);

        send_one(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, "basic");
        send_one(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "ripple");

        // Back-to-back stream of the whole table
        rx  = 0;
        gap = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (c < 16) drive(c, 1'b1);
            else        bus.in_valid = 1'b0;
            @(negedge clk);
            if (c < 16) check($sformatf("stream_in_ready%0d", c), 32'(bus.in_ready), 32'd1);
            if (bus.out_valid) begin
                if (rx < 16) begin
                    check($sformatf("stream_sum%0d", rx),  32'(bus.out_sum),  32'(tbl[rx].sum));
                    check($sformatf("stream_cout%0d", rx), 32'(bus.out_cout), 32'(tbl[rx].cout));
                end
                rx++;
            end else if (rx > 0 && rx < 16) begin
                gap++;
            end
        end
        check("stream_count", 32'(rx), 32'd16);
        check("stream_gaps",  32'(gap), 32'd0);

        // Fill with out_ready low, then pop and push in the same cycle
        bus.out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            drive(5 + j, 1'b1);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("stall_in_ready",  32'(bus.in_ready),  32'd0);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stall_sum",       32'(bus.out_sum),   32'(tbl[5].sum));
        held = bus.out_sum;
        repeat (2) @(negedge clk);
        check("stall_sum_stable", 32'(bus.out_sum),   32'(held));
        check("stall_still_full", 32'(bus.in_ready),  32'd0);
        @(posedge clk); #1;
        drive(9, 1'b1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("pushpop_in_ready", 32'(bus.in_ready), 32'd1);
        check("pushpop_head_sum", 32'(bus.out_sum),  32'(tbl[5].sum));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        drain(6, 4, "pushpop");

        // Reset with three beats in flight and a beat offered during reset
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            drive(10 + j, 1'b1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        drive(13, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_sum",   32'(bus.out_sum),   32'd0);
        check("midrst_out_cout",  32'(bus.out_cout),  32'd0);
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) stray++;
        end
        check("midrst_no_stale", 32'(stray), 32'd0);
        send_one(8'h99, 8'h99, 1'b0, 8'h32, 1'b1, "post_rst");

`ifdef PLADD_SUB_EN
        bus.in_sub = 1'b1;
        send_one(8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, "sub_borrow");
        send_one(8'h20, 8'h10, 1'b0, 8'h10, 1'b1, "sub_noborrow");
        bus.in_sub = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
